// File: rtl/pixel_serializer.sv
// rtl/pixel_serializer.sv - frame pixel fetcher and dibit serializer
// Streams FRAME_PIXELS pixels from a fixed-latency BRAM as 2-bit words with stall backpressure.
module pixel_serializer #(
   parameter int PIXEL_W      = 8,
   parameter int ADDR_W       = 17,
   parameter int FRAME_PIXELS = 76800,
   parameter int BRAM_LAT     = 2,
   parameter int MSB_FIRST    = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [PIXEL_W-1:0] pixel,
   input  logic               stall,
   output logic [ADDR_W-1:0]  pixel_addr,
   output logic               axiov,
   output logic [1:0]         axiod,
   output logic               busy,
   output logic               frame_done
);
   localparam int DIBITS = PIXEL_W / 2;
   localparam int DEPTH  = BRAM_LAT + 2;
   localparam int PW     = $clog2(DEPTH);
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int DW     = (DIBITS > 1) ? $clog2(DIBITS) : 1;
   localparam logic [ADDR_W:0] FRAME_N  = (ADDR_W+1)'(FRAME_PIXELS);
   localparam logic [ADDR_W:0] LAST_PIX = (ADDR_W+1)'(FRAME_PIXELS - 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t             state_q;
   logic [ADDR_W:0]    issued_q, out_cnt_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [BRAM_LAT:0]  vld_q;
   logic [PIXEL_W-1:0] mem_q [DEPTH];
   logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]      occ_q, inflight;
   logic [CW:0]        pending;
   logic [PIXEL_W-1:0] sh_q, sh_next;
   logic               sh_vld_q, done_q;
   logic [DW-1:0]      dib_q;
   logic               transfer, last_dib, fifo_wr, fifo_rd, accept, issue;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i <= BRAM_LAT; i++) inflight = inflight + CW'(vld_q[i]);
   end

   assign pending  = {1'b0, occ_q} + {1'b0, inflight};
   assign transfer = sh_vld_q && !stall;
   assign last_dib = (dib_q == DW'(DIBITS - 1));
   // vld_q[BRAM_LAT] marks the cycle the BRAM data for an issued address is on the pixel bus
   assign fifo_wr  = vld_q[BRAM_LAT];
   assign fifo_rd  = (occ_q != '0) && (!sh_vld_q || (transfer && last_dib));
   assign accept   = (state_q == IDLE) && start && !done_q;
   assign issue    = (state_q == RUN) && (issued_q < FRAME_N) && (pending < (CW+1)'(DEPTH));
   assign sh_next  = (MSB_FIRST != 0) ? (sh_q << 2) : (sh_q >> 2);

   assign pixel_addr = addr_q;
   assign axiov      = sh_vld_q;
   assign axiod      = (MSB_FIRST != 0) ? sh_q[PIXEL_W-1 -: 2] : sh_q[1:0];
   assign busy       = (state_q == RUN);
   assign frame_done = done_q;

   always_ff @(posedge clk) begin
      if (fifo_wr) mem_q[wr_ptr_q] <= pixel;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         issued_q  <= '0;
         out_cnt_q <= '0;
         addr_q    <= '0;
         vld_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         occ_q     <= '0;
         sh_q      <= '0;
         sh_vld_q  <= 1'b0;
         dib_q     <= '0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         vld_q  <= {vld_q[BRAM_LAT-1:0], issue};
         if (accept) begin
            state_q   <= RUN;
            issued_q  <= '0;
            out_cnt_q <= '0;
         end
         if (issue) begin
            addr_q   <= issued_q[ADDR_W-1:0];
            issued_q <= issued_q + (ADDR_W+1)'(1);
         end
         if (fifo_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (fifo_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (fifo_wr && !fifo_rd)      occ_q <= occ_q + CW'(1);
         else if (!fifo_wr && fifo_rd) occ_q <= occ_q - CW'(1);
         if (fifo_rd) begin
            sh_q     <= mem_q[rd_ptr_q];
            sh_vld_q <= 1'b1;
            dib_q    <= '0;
         end else if (transfer) begin
            if (last_dib) begin
               sh_q     <= '0;
               sh_vld_q <= 1'b0;
               dib_q    <= '0;
            end else begin
               sh_q  <= sh_next;
               dib_q <= dib_q + DW'(1);
            end
         end
         if (transfer && last_dib) begin
            out_cnt_q <= out_cnt_q + (ADDR_W+1)'(1);
            if ((state_q == RUN) && (out_cnt_q == LAST_PIX)) begin
               state_q <= IDLE;
               done_q  <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_pixel_serializer.sv
// tb/tb_pixel_serializer.sv - self-checking bench for pixel_serializer
// Two instances (LSB-first 4-pixel frame, MSB-first 1-pixel frame) share stimulus.
module tb_pixel_serializer;
   localparam int AW   = 8;
   localparam int NP0  = 4;
   localparam int NP1  = 1;
   localparam int LAT0 = 2;
   localparam int LAT1 = 3;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0;
   logic [7:0]    pixel [2];
   logic [AW-1:0] addr  [2];
   logic          axiov [2];
   logic [1:0]    axiod [2];
   logic          busy  [2];
   logic          done  [2];

   int checks = 0, failures = 0;

   pixel_serializer #(.PIXEL_W(8), .ADDR_W(AW), .FRAME_PIXELS(NP0), .BRAM_LAT(LAT0), .MSB_FIRST(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .pixel(pixel[0]), .stall(stall),
      .pixel_addr(addr[0]), .axiov(axiov[0]), .axiod(axiod[0]), .busy(busy[0]), .frame_done(done[0]));
   pixel_serializer #(.PIXEL_W(8), .ADDR_W(AW), .FRAME_PIXELS(NP1), .BRAM_LAT(LAT1), .MSB_FIRST(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .pixel(pixel[1]), .stall(stall),
      .pixel_addr(addr[1]), .axiov(axiov[1]), .axiod(axiod[1]), .busy(busy[1]), .frame_done(done[1]));

   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input int a);
      logic [7:0] t;
      t = 8'(a);
      return 8'hE4 ^ 8'(t * 8'd59);
   endfunction

   function automatic logic [1:0] exp_dibit(input int inst, input int n);
      logic [7:0] p;
      int k;
      p = pat(n / 4);
      k = n % 4;
      if (inst == 1) return 2'((p >> (6 - 2 * k)) & 8'd3);
      return 2'((p >> (2 * k)) & 8'd3);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // BRAM: data in a cycle belongs to the address presented BRAM_LAT cycles earlier
   logic [AW-1:0] hist [2][4];
   initial begin
      for (int i = 0; i < 2; i++) for (int j = 0; j < 4; j++) hist[i][j] = '0;
      pixel[0] = pat(0);
      pixel[1] = pat(0);
   end
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         for (int j = 3; j > 0; j--) hist[i][j] = hist[i][j-1];
         hist[i][0] = addr[i];
      end
      pixel[0] = pat(int'(hist[0][LAT0]));
      pixel[1] = pat(int'(hist[1][LAT1]));
   end

   int         idx [2] = '{0, 0};
   int         tmr [2] = '{0, 0};
   int         first_lat [2] = '{0, 0};
   int         done_cnt [2] = '{0, 0};
   int         ncap [2] = '{0, 0};
   logic [1:0] cap [2][4];
   logic [1:0] prev_d [2];
   logic [AW-1:0] last_addr [2];
   bit m_busy [2] = '{0, 0};
   bit done_exp [2] = '{0, 0};
   bit first [2] = '{0, 0};
   bit fresh [2] = '{0, 0};
   bit prev_hold [2] = '{0, 0};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int np, lat;
         bit cur_busy, cur_done;
         logic [AW-1:0] ea;
         np  = (i == 0) ? NP0 : NP1;
         lat = (i == 0) ? LAT0 : LAT1;
         if (!rst_n) begin
            chk("rst_addr", 32'(addr[i]), 0);
            chk("rst_axiov", 32'(axiov[i]), 0);
            chk("rst_axiod", 32'(axiod[i]), 0);
            chk("rst_busy", 32'(busy[i]), 0);
            chk("rst_done", 32'(done[i]), 0);
            m_busy[i] = 0; done_exp[i] = 0; idx[i] = 0; prev_hold[i] = 0;
            first[i] = 0; last_addr[i] = '0;
         end else begin
            tmr[i]++;
            cur_busy = m_busy[i];
            cur_done = done_exp[i];
            chk("frame_done", 32'(done[i]), 32'(done_exp[i]));
            chk("busy", 32'(busy[i]), 32'(m_busy[i]));
            if (done[i]) done_cnt[i]++;
            if (prev_hold[i]) begin
               chk("hold_axiov", 32'(axiov[i]), 1);
               chk("hold_axiod", 32'(axiod[i]), 32'(prev_d[i]));
            end
            if (axiov[i]) begin
               if (!m_busy[i] || idx[i] >= np * 4) chk("spurious_axiov", 32'(axiov[i]), 0);
               else begin
                  chk("axiod", 32'(axiod[i]), 32'(exp_dibit(i, idx[i])));
                  if (first[i]) begin
                     chk("first_latency", 32'(tmr[i]), 32'(lat + 3));
                     first_lat[i] = tmr[i];
                     first[i] = 0;
                  end
               end
            end else chk("axiod_idle", 32'(axiod[i]), 0);
            if (addr[i] != last_addr[i]) begin
               ea = fresh[i] ? '0 : last_addr[i] + 1'b1;
               chk("addr_seq", 32'(addr[i]), 32'(ea));
               fresh[i] = 0;
            end
            chk("addr_range", 32'(int'(addr[i]) < np), 1);
            last_addr[i] = addr[i];
            done_exp[i] = 0;
            if (axiov[i] && !stall && m_busy[i] && idx[i] < np * 4) begin
               if (ncap[i] < 4) begin cap[i][ncap[i]] = axiod[i]; ncap[i]++; end
               idx[i]++;
               if (idx[i] == np * 4) begin
                  done_exp[i] = 1;
                  m_busy[i] = 0;
                  chk("final_addr", 32'(last_addr[i]), 32'(np - 1));
               end
            end
            prev_hold[i] = axiov[i] && stall;
            prev_d[i] = axiod[i];
            if (start && !cur_busy && !cur_done) begin
               m_busy[i] = 1; idx[i] = 0; tmr[i] = -1; first[i] = 1;
               fresh[i] = (last_addr[i] != '0);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy[0] || busy[1] || done[0] || done[1]) && n < 1000) begin cyc(1); n++; end
      if (n >= 1000) begin
         checks++; failures++;
         $display("FAIL wait_idle: still busy after %0d cycles", n);
      end
      cyc(2);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      cyc(3);
      rst_n = 1'b1;
      cyc(2);
      chk("reset_addr0", 32'(addr[0]), 0);
      chk("reset_axiov0", 32'(axiov[0]), 0);

      // plain frame, plus a start while busy that must be ignored
      pulse_start();
      cyc(3);
      pulse_start();
      wait_idle();
      chk("lsb_d0", 32'(cap[0][0]), 0);
      chk("lsb_d1", 32'(cap[0][1]), 1);
      chk("lsb_d2", 32'(cap[0][2]), 2);
      chk("lsb_d3", 32'(cap[0][3]), 3);
      chk("msb_d0", 32'(cap[1][0]), 3);
      chk("msb_d1", 32'(cap[1][1]), 2);
      chk("msb_d2", 32'(cap[1][2]), 1);
      chk("msb_d3", 32'(cap[1][3]), 0);
      chk("lat_lit0", 32'(first_lat[0]), 5);
      chk("lat_lit1", 32'(first_lat[1]), 6);
      chk("done_cnt_f1", 32'(done_cnt[0]), 1);

      // random backpressure
      pulse_start();
      n = 0;
      while ((busy[0] || busy[1]) && n < 2000) begin
         stall = 1'($urandom_range(0, 1));
         cyc(1);
         n++;
      end
      stall = 1'b0;
      wait_idle();

      // stall held on final dibit, then start on frame_done cycle and one later
      pulse_start();
      n = 0;
      while (!(axiov[0] && idx[0] == NP0 * 4 - 1) && n < 200) begin cyc(1); n++; end
      chk("reach_last_dibit", 32'(n < 200), 1);
      stall = 1'b1;
      cyc(10);
      chk("no_done_while_stalled", 32'(done[0]), 0);
      stall = 1'b0;
      n = 0;
      while (!done[0] && n < 50) begin cyc(1); n++; end
      chk("done_after_release", 32'(n), 1);
      start = 1'b1;
      cyc(1);
      cyc(1);
      start = 1'b0;
      chk("restart_busy", 32'(busy[0]), 1);
      wait_idle();

      // reset mid-frame, then a clean frame from address 0
      pulse_start();
      cyc(8);
      rst_n = 1'b0;
      #1;
      chk("async_rst_axiov", 32'(axiov[0]), 0);
      chk("async_rst_busy", 32'(busy[0]), 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(2);
      pulse_start();
      wait_idle();
      chk("done_cnt_total0", 32'(done_cnt[0]), 5);
      chk("done_cnt_total1", 32'(done_cnt[1]), 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
